// File: rtl/handshake_buffer_pkg.sv
// Shared helpers and mode constants for handshake_buffer.
// The optional flush port is enabled with HANDSHAKE_BUFFER_FLUSH_EN.
package handshake_pkg;

    localparam int MODE_HALF = 0;
    localparam int MODE_FULL = 1;

    function automatic int levelWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    // At least one bit so a single-entry buffer still has a legal pointer.
    function automatic int ptrWidth(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/handshake_buffer_if.sv
// Valid/ready bus between an upstream producer, the buffer and a downstream consumer.
// The flush signal exists only when HANDSHAKE_BUFFER_FLUSH_EN is defined.
interface handshake_buffer_if #(
    parameter int W  = 16,
    parameter int LW = 2
);
    logic          inValid;
    logic          inReady;
    logic [W-1:0]  dIn;
    logic          outValid;
    logic          outReady;
    logic [W-1:0]  dOut;
    logic [LW-1:0] levelOut;
`ifdef HANDSHAKE_BUFFER_FLUSH_EN
    logic          flush;

    modport master (output inValid, dIn, outReady, flush,
                    input  inReady, outValid, dOut, levelOut);
    modport slave  (input  inValid, dIn, outReady, flush,
                    output inReady, outValid, dOut, levelOut);
`else
    modport master (output inValid, dIn, outReady,
                    input  inReady, outValid, dOut, levelOut);
    modport slave  (input  inValid, dIn, outReady,
                    output inReady, outValid, dOut, levelOut);
`endif
endinterface

// File: rtl/handshake_buffer_ctrl.sv
// Pointer, occupancy and ready/valid generation for handshake_buffer; no data path.
// Synchronous flush is compiled in with HANDSHAKE_BUFFER_FLUSH_EN.
module handshake_buffer_ctrl
    import handshake_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int FULL  = MODE_FULL,
    parameter int PW    = ptrWidth(DEPTH),
    parameter int LW    = levelWidth(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    output logic          dn_valid,
    input  logic          dn_ready,
`ifdef HANDSHAKE_BUFFER_FLUSH_EN
    input  logic          flush,
`endif
    output logic          push,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [LW-1:0] level
);

    logic          ready_init;
    logic [LW-1:0] count;
    logic          ready_raw;
    logic          valid_raw;
    logic          clear;
    logic          pop;

    // Half mode parks both pointers on entry 0.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (FULL == MODE_HALF || p == PW'(DEPTH - 1))
            return '0;
        return p + 1'b1;
    endfunction

    generate
        if (FULL == MODE_FULL) begin : g_full
            assign ready_raw = ready_init && (count != LW'(DEPTH));
        end else begin : g_half
            assign ready_raw = ready_init && (count == '0);
        end
    endgenerate

    assign valid_raw = (count != '0);

`ifdef HANDSHAKE_BUFFER_FLUSH_EN
    assign clear = flush;
`else
    assign clear = 1'b0;
`endif

    assign up_ready = ready_raw && !clear;
    assign dn_valid = valid_raw && !clear;
    assign push     = up_valid && up_ready;
    assign pop      = dn_valid && dn_ready;
    assign level    = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_init <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            ready_init <= 1'b1;
            if (clear) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= ptr_next(wr_ptr);
                if (pop)
                    rd_ptr <= ptr_next(rd_ptr);
                if (push && !pop)
                    count <= count + 1'b1;
                else if (pop && !push)
                    count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/handshake_buffer.sv
// Registered valid/ready buffer of DEPTH entries with fill level; storage and head mux.
// Optional synchronous flush via HANDSHAKE_BUFFER_FLUSH_EN.
module handshake_buffer
    import handshake_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 2,
    parameter int FULL  = MODE_FULL
) (
    input logic              clk,
    input logic              rst,
    handshake_buffer_if.slave bus
);

    localparam int LW = levelWidth(DEPTH);
    localparam int PW = ptrWidth(DEPTH);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("handshake_buffer: DEPTH must be at least 1");
        end
        if (FULL == MODE_FULL && DEPTH < 2) begin : g_bad_full
            $error("handshake_buffer: full-throughput mode needs DEPTH >= 2");
        end
    endgenerate

    logic [W-1:0]  mem [DEPTH];
    logic          push;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;

    handshake_buffer_ctrl #(
        .DEPTH (DEPTH),
        .FULL  (FULL),
        .PW    (PW),
        .LW    (LW)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .up_valid (bus.inValid),
        .up_ready (bus.inReady),
        .dn_valid (bus.outValid),
        .dn_ready (bus.outReady),
`ifdef HANDSHAKE_BUFFER_FLUSH_EN
        .flush    (bus.flush),
`endif
        .push     (push),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .level    (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= bus.dIn;
        end
    end

    assign bus.dOut     = mem[rd_ptr];
    assign bus.levelOut = level;

endmodule
